// File: rtl/md_unit.sv
// md_unit - multicycle multiply/divide unit owning the MIPS HI/LO registers.
//
// Runs mult, multu, div and divu in 33 cycles (32 shift-add / restoring-divide
// iterations plus one sign-fix/commit cycle). Also services mthi/mtlo writes.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, clears all state
//   start  - one-cycle operation request, sampled only in IDLE
//   op     - 00 mult, 01 multu, 10 div, 11 divu
//   A, B   - rs / rt operands, only sampled on the start edge
//   hi_we  - mthi write enable (IDLE only)
//   lo_we  - mtlo write enable (IDLE only)
//   wdata  - mthi/mtlo write data
//   busy   - high from the edge after start until result commit
//   done   - one-cycle pulse coincident with the HI/LO update
//   hi, lo - HI and LO registers
//
// state | meaning
// IDLE  | waiting for start, accepts mthi/mtlo
// CALC  | one multiplier / quotient bit per cycle, WIDTH cycles
// FIX   | sign correction and HI/LO commit, done pulse
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic             op_div;
  logic             neg_q;    // quotient / product negation
  logic             neg_r;    // remainder takes sign of dividend
  logic             div0;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier shifting out, or dividend -> quotient
  logic [WIDTH-1:0] opb;      // multiplicand magnitude or divisor magnitude

  logic             signed_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (signed_op && B[WIDTH-1]) ? -B : B;

  // Multiply step: conditionally add multiplicand to the high half, then
  // shift the whole product right; the carry lands in the top bit.
  assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

  // Restoring divide step: the sign bit of the trial difference is the borrow.
  assign trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  // Divide by zero: the magnitude algorithm already leaves |A| as remainder,
  // so the remainder sign rule restores A; only the quotient is forced.
  assign q_fix    = div0 ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div <= op[1];
            neg_q  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= signed_op & A[WIDTH-1];
            div0   <= op[1] && (B == '0);
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? mag_a : mag_b;
            opb    <= op[1] ? mag_b : mag_a;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (op_div) begin
            if (!trial[WIDTH]) begin
              acc_hi <= trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multicycle multiply/divide unit for the MIPS datapath; runs mult, multu, div and divu and owns the HI/LO registers.
- Sits beside the single-cycle ALU, which handles add/sub, compare, logic and shift but not mult/div.
- Control issues a start pulse with operands, then stalls the pipeline while busy=1.
- Also services mthi/mtlo writes; mfhi/mflo read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  high from the edge after start until result commit.
- done  output  1  one-cycle pulse, coincident with HI/LO update.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts the operation; HI/LO are cleared to 0, not left holding partial results.
- States: IDLE, CALC, FIX.
- IDLE, start=1 (edge E0):
  - Latch op.
  - Latch |A| and |B| for signed ops (op[0]=0); latch raw A and B for unsigned ops.
  - Record sign flags.
  - counter=0, busy=1, go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH product register.
- CALC, divide: restoring division, one quotient bit per cycle into a WIDTH remainder/quotient pair.
- CALC exit: after exactly WIDTH edges (E1..E32), counter wraps 31→0 and the FSM moves to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - Write hi/lo, done=1, busy=0, go to IDLE.
  - Result is therefore visible 33 cycles after the start edge.
- done is cleared on the following edge.
- Sign rules, signed mult: negate the 64-bit product iff sign(A) XOR sign(B).
- Sign rules, signed div:
  - quotient is negated iff sign(A) XOR sign(B);
  - remainder takes the sign of A;
  - quotient truncates toward zero.
- Result mapping:
  - mult/multu: {hi,lo} = 64-bit product.
  - div/divu: lo = quotient, hi = remainder.
- Divide by zero (B=0, div or divu): no trap; lo=0xFFFFFFFF, hi=A (original signed/unsigned dividend bits). Latency is unchanged at 33 cycles.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special casing.
- start while busy=1: ignored; the operation in flight is unaffected.
- hi_we/lo_we in IDLE without start: hi/lo ← wdata on that edge. Both may assert together.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we in the same cycle as an accepted start: the writes are ignored; the result will overwrite HI/LO.
- Operand inputs are don't-care after the start edge; they may change freely.
- HI/LO hold their value between operations; they are never cleared except by reset.

Test Plan:
- Reset during CALC at cycle 10 of a mult → busy=0, hi=lo=0, done never pulses. A following multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start.
- mult −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same operands with multu → hi=0x00000006, lo=0xFFFFFFEB.
- div −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). divu 100/7 → lo=14, hi=2.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. divu 5/0 → lo=0xFFFFFFFF, hi=5, latency 33.
- hi_we=1, lo_we=1, wdata=0x12345678 in IDLE → hi=lo=0x12345678 next edge. Start a mult, then pulse start and hi_we at cycle 5 → both ignored, result correct, busy remains 1 until commit.
- Back-to-back: start issued the cycle after done → accepted. done is one cycle wide, busy is 33 cycles per operation, and HI/LO are stable between operations.
